// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Purpose:
//   Fills the instruction memory from a byte stream. The stream carries a
//   little-endian length (number of instruction words, two stream bytes)
//   followed by the instruction words themselves, each sent least
//   significant byte first. Every completed word is written to memory at
//   BASE_ADDR + 4*n as a single-cycle write. The CPU is held in reset until
//   the whole image has been written.
//
// Ports:
//   clk        in   1               clock, rising edge
//   rst        in   1               asynchronous, active-high reset
//   start      in   1               pulse: begin a (re)load
//   in_valid   in   1               stream byte valid
//   in_data    in   DATA_WIDTH      stream byte
//   in_ready   out  1               loader can accept a byte
//   mem_we     out  1               word write strobe, one cycle per word
//   mem_addr   out  ADDRESS_WIDTH   byte address of the write (word aligned)
//   mem_wdata  out  DATA_OUT_WIDTH  word to write
//   cpu_hold   out  1               keep the CPU in reset while 1
//   done       out  1               load completed successfully
//   err        out  1               requested length exceeds memory capacity
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int ADDRESS_WIDTH      = 32,
    parameter int ADDRESS_REAL_WIDTH = 12,
    parameter int DATA_WIDTH         = 8,
    parameter int DATA_OUT_WIDTH     = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      in_ready,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_OUT_WIDTH-1:0] mem_wdata,
    output logic                      cpu_hold,
    output logic                      done,
    output logic                      err
);

    localparam int BYTES_PER_WORD = DATA_OUT_WIDTH / DATA_WIDTH;
    localparam int BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int LEN_W          = 2 * DATA_WIDTH;
    localparam int WORD_BYTES     = DATA_OUT_WIDTH / 8;

    localparam logic [63:0] CAPACITY_WORDS = 64'(1) << (ADDRESS_REAL_WIDTH - 2);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     len_lo;
    logic [LEN_W-1:0]          last_word;
    logic [LEN_W-1:0]          word_cnt;
    logic [BYTE_IDX_W-1:0]     byte_idx;
    logic [DATA_OUT_WIDTH-1:0] word_buf;

    logic                      accept;
    logic [LEN_W-1:0]          len_full;
    logic                      len_too_big;
    logic [DATA_OUT_WIDTH-1:0] next_word;
    logic [ADDRESS_WIDTH-1:0]  word_addr;

    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len_lo};

    // Widen to 64 bits so the capacity compare works for any parameter mix.
    assign len_too_big = 64'(len_full) > CAPACITY_WORDS;

    // Word-aligned address of the word being completed; wraps modulo
    // 2**ADDRESS_WIDTH by construction of the fixed-width sum.
    assign word_addr = BASE_ADDR + (ADDRESS_WIDTH'(word_cnt) * ADDRESS_WIDTH'(WORD_BYTES));

    // Assembly buffer with the incoming byte merged into its lane, so the
    // final byte of a word can be written out in the same edge it arrives.
    always_comb begin
        next_word = word_buf;
        next_word[byte_idx*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    // Load sequencer. All outputs are registered here; mem_we defaults low
    // every cycle so each completed word produces exactly one write pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            len_lo    <= '0;
            last_word <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN_LO;
                        in_ready <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        word_buf <= '0;
                    end
                end

                S_LEN_LO: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (accept) begin
                        if (len_full == '0) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (len_too_big) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state     <= S_DATA;
                            last_word <= len_full - LEN_W'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        if (byte_idx == LAST_BYTE) begin
                            // Output registers are separate from word_buf, so
                            // the next word can start assembling immediately.
                            mem_we    <= 1'b1;
                            mem_wdata <= next_word;
                            mem_addr  <= word_addr;
                            byte_idx  <= '0;
                            word_buf  <= '0;
                            if (word_cnt == last_word) begin
                                state    <= S_FLUSH;
                                in_ready <= 1'b0;
                            end else begin
                                word_cnt <= word_cnt + LEN_W'(1);
                            end
                        end else begin
                            word_buf <= next_word;
                            byte_idx <= byte_idx + BYTE_IDX_W'(1);
                        end
                    end
                end

                // The final write pulse is visible during this state.
                S_FLUSH: begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Purpose:
//   Self-checking bench for instr_mem_loader. Byte streams are driven with
//   random valid gaps; a reference model derived from the stream contents
//   (length field, little-endian word packing, acceptance cycles) predicts
//   every memory write, its cycle, and the final done/err outcome.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int CAP_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    instr_mem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Count of rising edges; at a falling edge it names the edge just past.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Write and status monitor, sampled on the falling edge.
    logic [31:0] gotAddr[$];
    logic [31:0] gotData[$];
    int          gotCyc[$];
    int          doneCyc = -1;
    int          errCyc  = -1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            gotAddr.push_back(mem_addr);
            gotData.push_back(mem_wdata);
            gotCyc.push_back(cyc);
        end
        if (done === 1'b1 && doneCyc < 0) doneCyc = cyc;
        if (err === 1'b1 && errCyc < 0) errCyc = cyc;
    end

    logic [7:0] stim[$];
    int         accCyc[$];

    task automatic setTest1Stream();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hF0, 8'h0F};
    endtask

    task automatic startLoad();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        gotAddr.delete();
        gotData.delete();
        gotCyc.delete();
        accCyc.delete();
        doneCyc = -1;
        errCyc  = -1;
        checkOutput("ready_after_start", 64'(in_ready), 64'(1));
        checkOutput("hold_after_start", 64'(cpu_hold), 64'(1));
    endtask

    // Drives the first nBytes of stim; records the edge at which each byte
    // is taken. Optionally toggles start randomly while the load is busy and
    // once more on the edge where the loader is flushing its last word.
    task automatic applyStimulus(input int nBytes, input int validPct,
                                 input bit pokeStart, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < nBytes; i++) begin
            bit taken;
            int waited;
            taken  = 1'b0;
            waited = 0;
            while (!taken && ok) begin
                @(negedge clk);
                in_valid = ($urandom_range(99) < validPct);
                in_data  = in_valid ? stim[i] : 8'($urandom);
                if (pokeStart) start = 1'($urandom_range(1));
                taken = in_valid && in_ready;
                if (taken) accCyc.push_back(cyc + 1);
                waited++;
                if (!taken && waited > 400) ok = 1'b0;
            end
            if (!ok) break;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = pokeStart;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runLoad(input int validPct, input bit pokeStart);
        int len;
        int nSend;
        bit ok;
        len = int'(stim[0]) + 256 * int'(stim[1]);
        nSend = (len == 0 || len > CAP_WORDS) ? 2 : 2 + 4 * len;
        startLoad();
        applyStimulus(nSend, validPct, pokeStart, ok);
        checkOutput("stream_taken", 64'(ok), 64'(1));
        if (!ok) return;
        for (int k = 0; k < 20 && doneCyc < 0 && errCyc < 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);

        if (len > CAP_WORDS) begin
            checkOutput("err_cycle", 64'(errCyc), 64'(accCyc[1]));
            checkOutput("err_writes", 64'(gotAddr.size()), 64'(0));
            checkOutput("err_flag", 64'(err), 64'(1));
            checkOutput("err_hold", 64'(cpu_hold), 64'(1));
            checkOutput("err_ready", 64'(in_ready), 64'(0));
            checkOutput("err_done", 64'(done), 64'(0));
        end else begin
            checkOutput("write_count", 64'(gotAddr.size()), 64'(len));
            for (int i = 0; i < len && i < gotAddr.size(); i++) begin
                logic [31:0] word;
                word = {stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]};
                checkOutput($sformatf("addr[%0d]", i), 64'(gotAddr[i]), 64'(32'(4 * i)));
                checkOutput($sformatf("data[%0d]", i), 64'(gotData[i]), 64'(word));
                checkOutput($sformatf("we_cycle[%0d]", i), 64'(gotCyc[i]), 64'(accCyc[2+4*i+3]));
            end
            if (len == 0)
                checkOutput("done_cycle", 64'(doneCyc), 64'(accCyc[1]));
            else
                checkOutput("done_cycle", 64'(doneCyc), 64'(accCyc[accCyc.size()-1] + 1));
            checkOutput("done_flag", 64'(done), 64'(1));
            checkOutput("done_hold", 64'(cpu_hold), 64'(0));
            checkOutput("done_err", 64'(err), 64'(0));
            checkOutput("done_ready", 64'(in_ready), 64'(0));
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 64'(in_ready), 64'(0));
        checkOutput({tag, "_we"}, 64'(mem_we), 64'(0));
        checkOutput({tag, "_addr"}, 64'(mem_addr), 64'(0));
        checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
        checkOutput({tag, "_hold"}, 64'(cpu_hold), 64'(1));
        checkOutput({tag, "_done"}, 64'(done), 64'(0));
        checkOutput({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        bit ok;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", 64'(in_ready), 64'(0));
        checkOutput("idle_hold", 64'(cpu_hold), 64'(1));

        $display("[TB] two-word load, continuous stream");
        setTest1Stream();
        runLoad(100, 1'b0);
        if (gotData.size() == 2) begin
            checkOutput("t1_word0", 64'(gotData[0]), 64'(32'h00500513));
            checkOutput("t1_word1", 64'(gotData[1]), 64'(32'h0FF00593));
            checkOutput("t1_addr1", 64'(gotAddr[1]), 64'(32'h4));
        end

        $display("[TB] two-word load, gappy stream");
        runLoad(50, 1'b0);

        $display("[TB] zero-length load");
        stim = '{8'h00, 8'h00};
        runLoad(100, 1'b0);

        $display("[TB] over-capacity length then recovery");
        stim = '{8'h01, 8'h04};
        runLoad(100, 1'b0);
        setTest1Stream();
        runLoad(70, 1'b0);

        $display("[TB] reset in the middle of the data phase");
        setTest1Stream();
        startLoad();
        applyStimulus(8, 100, 1'b0, ok);
        checkOutput("mid_stream_taken", 64'(ok), 64'(1));
        checkOutput("mid_ready_before_rst", 64'(in_ready), 64'(1));
        #2 rst = 1'b1;
        #1 checkResetValues("async_rst");
        checkOutput("mid_write_count", 64'(gotAddr.size()), 64'(1));
        if (gotData.size() == 1)
            checkOutput("mid_word0", 64'(gotData[0]), 64'(32'h00500513));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_idle_ready", 64'(in_ready), 64'(0));
        runLoad(100, 1'b0);

        $display("[TB] start pulses during data and flush");
        setTest1Stream();
        runLoad(60, 1'b1);

        $display("[TB] random loads");
        for (int t = 0; t < 8; t++) begin
            int len;
            len = $urandom_range(1, 12);
            stim.delete();
            stim.push_back(8'(len));
            stim.push_back(8'(len >> 8));
            for (int b = 0; b < 4 * len; b++) stim.push_back(8'($urandom));
            runLoad($urandom_range(30, 100), 1'($urandom_range(1)));
        end

        $display("[TB] full-capacity load");
        stim.delete();
        stim.push_back(8'h00);
        stim.push_back(8'h04);
        for (int b = 0; b < 4 * CAP_WORDS; b++) stim.push_back(8'($urandom));
        runLoad(100, 1'b0);

        $display("[TB] one word past capacity");
        stim = '{8'h01, 8'h04};
        runLoad(100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
